// File: rtl/cpu_sequencer.sv
// Instruction sequencer: fetch over req/ack, dispatch on decoder target state,
// drive the ALU start/done handshake and GPR write port, advance the PC.
module cpu_sequencer #(
   parameter logic [63:0] RESET_PC          = 64'h0,
   parameter logic [63:0] PC_STEP           = 64'd4,
   // Decoder target-state codes; must match the decoder's cpustate constants.
   parameter logic [3:0]  STATE_HALT        = 4'd0,
   parameter logic [3:0]  STATE_SRC1_TO_DST = 4'd1,
   parameter logic [3:0]  STATE_EXECUTE     = 4'd2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic        o_imem_req,
   output logic [63:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_data,
   output logic [31:0] o_insn,
   input  logic        i_dec_valid,
   input  logic [3:0]  i_dec_to_state,
   input  logic [63:0] i_dec_src1,
   input  logic [4:0]  i_dec_dst,
   output logic        o_alu_start,
   input  logic        i_alu_done,
   input  logic [63:0] i_alu_result,
   output logic        o_gpr_we,
   output logic [4:0]  o_gpr_waddr,
   output logic [63:0] o_gpr_wdata,
   output logic [63:0] o_pc,
   output logic        o_halted,
   output logic        o_fault
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_EXWAIT,
      S_WB,
      S_HALT,
      S_FAULT
   } state_t;

   state_t state;
   state_t next_state;

   logic fetch_done;
   logic load_dst;
   logic load_src1;
   logic load_result;

   assign o_imem_addr = o_pc;

   always_comb begin
      next_state  = state;
      fetch_done  = 1'b0;
      load_dst    = 1'b0;
      load_src1   = 1'b0;
      load_result = 1'b0;
      case (state)
         S_FETCH: begin
            // Ack only counts once the request is actually on the port.
            if (o_imem_req && i_imem_ack) begin
               fetch_done = 1'b1;
               next_state = S_DECODE;
            end
         end
         S_DECODE: begin
            if (!i_dec_valid) begin
               next_state = S_FAULT;
            end else if (i_dec_to_state == STATE_HALT) begin
               next_state = S_HALT;
            end else if (i_dec_to_state == STATE_SRC1_TO_DST) begin
               load_dst   = 1'b1;
               load_src1  = 1'b1;
               next_state = S_WB;
            end else if (i_dec_to_state == STATE_EXECUTE) begin
               load_dst   = 1'b1;
               next_state = S_EXEC;
            end else begin
               next_state = S_FAULT;
            end
         end
         S_EXEC: begin
            next_state = S_EXWAIT;
         end
         S_EXWAIT: begin
            if (i_alu_done) begin
               load_result = 1'b1;
               next_state  = S_WB;
            end
         end
         S_WB: begin
            next_state = S_FETCH;
         end
         S_HALT: begin
            next_state = S_HALT;
         end
         S_FAULT: begin
            next_state = S_FAULT;
         end
         default: begin
            next_state = S_FAULT;
         end
      endcase
   end

   // Strobes are registered from next_state so they are clean flops and all
   // read zero while reset is held.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= S_FETCH;
         o_imem_req  <= 1'b0;
         o_alu_start <= 1'b0;
         o_gpr_we    <= 1'b0;
         o_halted    <= 1'b0;
         o_fault     <= 1'b0;
      end else begin
         state       <= next_state;
         o_imem_req  <= (next_state == S_FETCH);
         o_alu_start <= (next_state == S_EXEC);
         o_gpr_we    <= (next_state == S_WB);
         o_halted    <= (next_state == S_HALT) || (next_state == S_FAULT);
         o_fault     <= (next_state == S_FAULT);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_insn      <= '0;
         o_gpr_waddr <= '0;
         o_gpr_wdata <= '0;
         o_pc        <= RESET_PC;
      end else begin
         if (fetch_done) begin
            o_insn <= i_imem_data;
         end
         if (load_dst) begin
            o_gpr_waddr <= i_dec_dst;
         end
         if (load_src1) begin
            o_gpr_wdata <= i_dec_src1;
         end else if (load_result) begin
            o_gpr_wdata <= i_alu_result;
         end
         if (state == S_WB) begin
            o_pc <= o_pc + PC_STEP;
         end
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: a small decoder model feeds the DUT and
// expected GPR writes are queued at fetch time and popped when o_gpr_we fires.
module tb_cpu_sequencer;

   localparam logic [3:0]  ST_HALT  = 4'd5;
   localparam logic [3:0]  ST_SRC1  = 4'd9;
   localparam logic [3:0]  ST_EXEC  = 4'd12;
   localparam logic [3:0]  ST_BOGUS = 4'd3;
   localparam logic [63:0] WRAP_PC  = 64'hFFFF_FFFF_FFFF_FFFC;

   typedef struct packed {
      logic        valid;
      logic [3:0]  to;
      logic [63:0] src1;
      logic [4:0]  dst;
   } dec_t;

   typedef struct packed {
      logic [4:0]  waddr;
      logic [63:0] wdata;
   } wr_t;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_imem_ack;
   logic [31:0] i_imem_data;
   logic        i_alu_done;
   logic [63:0] i_alu_result;

   logic        o_imem_req, o_alu_start, o_gpr_we, o_halted, o_fault;
   logic [63:0] o_imem_addr, o_gpr_wdata, o_pc;
   logic [31:0] o_insn;
   logic [4:0]  o_gpr_waddr;
   dec_t        dec;

   logic        w_imem_req, w_alu_start, w_gpr_we, w_halted, w_fault;
   logic [63:0] w_imem_addr, w_gpr_wdata, w_pc;
   logic [31:0] w_insn;
   logic [4:0]  w_gpr_waddr;
   dec_t        w_dec;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   int unsigned start_cnt = 0;
   wr_t         exp_q[$];

   always #5 i_clk = ~i_clk;

   // Decoder model: [31:30]=k, [25:21]=dst, [15:0]=imm; all-zero word is HALT.
   function automatic dec_t dec_f(input logic [31:0] insn);
      dec_t d;
      d.valid = 1'b1;
      d.to    = ST_BOGUS;
      d.src1  = {32'h0, insn};
      d.dst   = insn[25:21];
      if (insn == 32'h0) begin
         d.to = ST_HALT;
      end else begin
         case (insn[31:30])
            2'b00:   begin d.to = ST_SRC1; d.src1 = {48'h0, insn[15:0]}; end
            2'b01:   d.to = ST_EXEC;
            2'b10:   d.valid = 1'b0;
            default: d.to = ST_BOGUS;
         endcase
      end
      return d;
   endfunction

   function automatic logic [31:0] li(input logic [4:0] dst, input logic [15:0] imm);
      return {2'b00, 4'h0, dst, 5'h0, imm};
   endfunction

   function automatic logic [31:0] alu_op(input logic [4:0] dst);
      return {2'b01, 4'h0, dst, 21'h0};
   endfunction

   always_comb dec   = dec_f(o_insn);
   always_comb w_dec = dec_f(w_insn);

   cpu_sequencer #(
      .RESET_PC(64'h0), .PC_STEP(64'd4),
      .STATE_HALT(ST_HALT), .STATE_SRC1_TO_DST(ST_SRC1), .STATE_EXECUTE(ST_EXEC)
   ) u_dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
      .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data),
      .o_insn(o_insn),
      .i_dec_valid(dec.valid), .i_dec_to_state(dec.to),
      .i_dec_src1(dec.src1), .i_dec_dst(dec.dst),
      .o_alu_start(o_alu_start), .i_alu_done(i_alu_done), .i_alu_result(i_alu_result),
      .o_gpr_we(o_gpr_we), .o_gpr_waddr(o_gpr_waddr), .o_gpr_wdata(o_gpr_wdata),
      .o_pc(o_pc), .o_halted(o_halted), .o_fault(o_fault)
   );

   // Second instance starts just below 2^64 and sees identical stimulus.
   cpu_sequencer #(
      .RESET_PC(WRAP_PC), .PC_STEP(64'd4),
      .STATE_HALT(ST_HALT), .STATE_SRC1_TO_DST(ST_SRC1), .STATE_EXECUTE(ST_EXEC)
   ) u_wrap (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .o_imem_req(w_imem_req), .o_imem_addr(w_imem_addr),
      .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data),
      .o_insn(w_insn),
      .i_dec_valid(w_dec.valid), .i_dec_to_state(w_dec.to),
      .i_dec_src1(w_dec.src1), .i_dec_dst(w_dec.dst),
      .o_alu_start(w_alu_start), .i_alu_done(i_alu_done), .i_alu_result(i_alu_result),
      .o_gpr_we(w_gpr_we), .o_gpr_waddr(w_gpr_waddr), .o_gpr_wdata(w_gpr_wdata),
      .o_pc(w_pc), .o_halted(w_halted), .o_fault(w_fault)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge i_clk) begin
      if (o_alu_start) start_cnt++;
      if (o_gpr_we) begin
         if (exp_q.size() == 0) begin
            check_val("sb_unexpected_we", {63'h0, o_gpr_we}, 64'h0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check_val("sb_waddr", {59'h0, o_gpr_waddr}, {59'h0, e.waddr});
            check_val("sb_wdata", o_gpr_wdata, e.wdata);
         end
      end
   end

   // Called on a negedge; returns on the negedge of the DECODE cycle.
   task automatic do_fetch(input logic [31:0] insn, input int unsigned delay,
                           input logic [63:0] exp_addr);
      int unsigned n;
      n = 0;
      while (!o_imem_req && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      check_val("fetch_req_seen", {63'h0, o_imem_req}, 64'h1);
      check_val("fetch_addr", o_imem_addr, exp_addr);
      for (int unsigned i = 0; i < delay; i++) begin
         @(negedge i_clk);
         check_val("fetch_req_held", {63'h0, o_imem_req}, 64'h1);
         check_val("fetch_addr_stable", o_imem_addr, exp_addr);
      end
      i_imem_ack  = 1'b1;
      i_imem_data = insn;
      @(negedge i_clk);
      i_imem_ack  = 1'b0;
      i_imem_data = $urandom;
      check_val("fetch_req_drop", {63'h0, o_imem_req}, 64'h0);
      check_val("fetch_insn", {32'h0, o_insn}, {32'h0, insn});
   endtask

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_pc"}, o_pc, 64'h0);
      check_val({tag, "_insn"}, {32'h0, o_insn}, 64'h0);
      check_val({tag, "_wdata"}, o_gpr_wdata, 64'h0);
      check_val({tag, "_ctl"},
                {59'h0, o_imem_req, o_alu_start, o_gpr_we, o_halted, o_fault}, 64'h0);
      check_val({tag, "_waddr"}, {59'h0, o_gpr_waddr}, 64'h0);
   endtask

   task automatic do_reset();
      i_rst_n    = 1'b0;
      i_imem_ack = 1'b0;
      i_alu_done = 1'b0;
      exp_q.delete();
      @(negedge i_clk);
      check_reset_vals("rst");
      i_rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned s0, req_cnt;
      i_rst_n      = 1'b0;
      i_imem_ack   = 1'b0;
      i_imem_data  = '0;
      i_alu_done   = 1'b0;
      i_alu_result = '0;
      repeat (2) @(negedge i_clk);
      check_reset_vals("por");
      check_val("por_wrap_pc", w_pc, WRAP_PC);
      i_rst_n = 1'b1;
      check_val("req_low_before_edge", {63'h0, o_imem_req}, 64'h0);
      @(negedge i_clk);
      check_val("first_req", {63'h0, o_imem_req}, 64'h1);

      // LI r3,0x1234 with same-cycle ack
      exp_q.push_back('{waddr: 5'd3, wdata: 64'h1234});
      do_fetch(li(5'd3, 16'h1234), 0, 64'h0);
      check_val("li_we_early", {63'h0, o_gpr_we}, 64'h0);
      @(negedge i_clk);
      check_val("li_we_cycle3", {63'h0, o_gpr_we}, 64'h1);
      @(negedge i_clk);
      check_val("li_pc", o_pc, 64'h4);
      check_val("wrap_pc", w_pc, 64'h0);
      check_val("li_we_once", {63'h0, o_gpr_we}, 64'h0);

      // ALU op at pc 4, fetch ack delayed 5 cycles, stray done during EXEC
      s0 = start_cnt;
      exp_q.push_back('{waddr: 5'd7, wdata: 64'hDEAD_BEEF_0123_4567});
      do_fetch(alu_op(5'd7), 5, 64'h4);
      check_val("alu_start_decode", {63'h0, o_alu_start}, 64'h0);
      @(negedge i_clk);
      check_val("alu_start_pulse", {63'h0, o_alu_start}, 64'h1);
      i_alu_done   = 1'b1;
      i_alu_result = 64'h1111_2222_3333_4444;
      @(negedge i_clk);
      i_alu_done = 1'b0;
      check_val("alu_start_drop", {63'h0, o_alu_start}, 64'h0);
      check_val("alu_no_we_exec_done", {63'h0, o_gpr_we}, 64'h0);
      @(negedge i_clk);
      @(negedge i_clk);
      check_val("alu_wait_no_we", {63'h0, o_gpr_we}, 64'h0);
      i_alu_done   = 1'b1;
      i_alu_result = 64'hDEAD_BEEF_0123_4567;
      @(negedge i_clk);
      i_alu_done = 1'b0;
      check_val("alu_we", {63'h0, o_gpr_we}, 64'h1);
      @(negedge i_clk);
      check_val("alu_pc", o_pc, 64'h8);
      check_val("alu_start_count", 64'(start_cnt - s0), 64'h1);

      // HALT at pc 8, stray acks while halted
      do_fetch(32'h0, 0, 64'h8);
      @(negedge i_clk);
      check_val("halt_flags", {62'h0, o_halted, o_fault}, 64'h2);
      req_cnt = 0;
      for (int unsigned i = 0; i < 20; i++) begin
         i_imem_ack = i[0];
         @(negedge i_clk);
         if (o_imem_req) req_cnt++;
      end
      i_imem_ack = 1'b0;
      check_val("halt_no_req", 64'(req_cnt), 64'h0);
      check_val("halt_pc", o_pc, 64'h8);

      // Invalid instruction (k=2'b10) with stray done/ack pulses
      do_reset();
      do_fetch(32'h8060_0000, 0, 64'h0);
      @(negedge i_clk);
      check_val("fault_flags", {62'h0, o_halted, o_fault}, 64'h3);
      req_cnt = 0;
      for (int unsigned i = 0; i < 10; i++) begin
         i_alu_done = i[0];
         i_imem_ack = ~i[0];
         @(negedge i_clk);
         if (o_imem_req || o_alu_start) req_cnt++;
      end
      i_alu_done = 1'b0;
      i_imem_ack = 1'b0;
      check_val("fault_quiet", 64'(req_cnt), 64'h0);
      check_val("fault_pc", o_pc, 64'h0);

      // Valid decode but unknown target state
      do_reset();
      do_fetch(32'hC000_0001, 0, 64'h0);
      @(negedge i_clk);
      check_val("bogus_flags", {62'h0, o_halted, o_fault}, 64'h3);

      // LI r0 then reset in the middle of EXWAIT
      do_reset();
      exp_q.push_back('{waddr: 5'd0, wdata: 64'h55});
      do_fetch(li(5'd0, 16'h0055), 0, 64'h0);
      repeat (2) @(negedge i_clk);
      check_val("r0_pc", o_pc, 64'h4);
      exp_q.push_back('{waddr: 5'd9, wdata: 64'h99});
      do_fetch(alu_op(5'd9), 0, 64'h4);
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_reset_vals("midrst");
      @(negedge i_clk);
      i_alu_done   = 1'b1;
      i_alu_result = 64'h99;
      i_rst_n      = 1'b1;
      @(negedge i_clk);
      i_alu_done = 1'b0;
      check_val("restart_req", {63'h0, o_imem_req}, 64'h1);
      exp_q.push_back('{waddr: 5'd1, wdata: 64'hABCD});
      do_fetch(li(5'd1, 16'hABCD), 0, 64'h0);
      repeat (2) @(negedge i_clk);
      check_val("restart_pc", o_pc, 64'h4);

      check_val("sb_drained", 64'(exp_q.size()), 64'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
